// File: rtl/fsm_trigger_pkg.sv
// Shared types for the multi-channel trigger delay block.
// Channel FSM states and edge-select encodings.
package fsm_trigger_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DELAY = 2'd1,
      PULSE = 2'd2
   } trig_state_t;

   localparam logic EDGE_RISE = 1'b0;
   localparam logic EDGE_FALL = 1'b1;

endpackage

// File: rtl/trigger_delay_channel.sv
// One trigger channel: opto synchroniser, edge detect, delay/pulse FSM
// and accepted/missed trigger statistics.
module trigger_delay_channel
   import fsm_trigger_pkg::*;
#(
   parameter int CNT_WIDTH   = 32,
   parameter int SYNC_STAGES = 2,
   parameter int STAT_WIDTH  = 16
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  enable,
   input  logic                  edge_sel,
   input  logic                  sig_in,
   input  logic [CNT_WIDTH-1:0]  delay_cfg,
   input  logic [CNT_WIDTH-1:0]  width_cfg,
   input  logic                  stat_clear,
   output logic                  pulse_out,
   output logic                  busy,
   output logic [STAT_WIDTH-1:0] event_count,
   output logic [STAT_WIDTH-1:0] missed_count
);

   localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [STAT_WIDTH-1:0] STAT_ONE = STAT_WIDTH'(1);

   logic [SYNC_STAGES-1:0] sync_pipe;
   logic                   sync_hist;
   logic                   sync_now;
   logic                   trig;

   trig_state_t            state, state_nxt;
   logic [CNT_WIDTH-1:0]   cnt, cnt_nxt;
   logic [CNT_WIDTH-1:0]   d_lat, w_lat;
   logic                   accept, miss;
   logic                   pulse_nxt, busy_nxt;

   // sync_pipe[0] is the metastability-exposed stage; the newest usable sample is the top one
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_pipe <= '0;
         sync_hist <= 1'b0;
      end else begin
         sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], sig_in};
         sync_hist <= sync_pipe[SYNC_STAGES-1];
      end
   end

   assign sync_now = sync_pipe[SYNC_STAGES-1];
   assign trig     = (edge_sel == EDGE_RISE) ? (!sync_hist &&  sync_now)
                                             : ( sync_hist && !sync_now);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (!enable) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (trig) state_nxt = (delay_cfg != '0) ? DELAY : PULSE;
            DELAY:   if (cnt == d_lat - CNT_ONE) state_nxt = PULSE;
            PULSE:   if (cnt == w_lat - CNT_ONE) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Counter restarts on every state change and idles at zero
   always_comb begin
      accept    = enable && trig && (state == IDLE);
      miss      = enable && trig && (state != IDLE);
      cnt_nxt   = cnt + CNT_ONE;
      if ((state_nxt != state) || (state_nxt == IDLE)) cnt_nxt = '0;
      pulse_nxt = (state_nxt == PULSE);
      busy_nxt  = (state_nxt != IDLE);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt          <= '0;
         d_lat        <= '0;
         w_lat        <= CNT_ONE;
         pulse_out    <= 1'b0;
         busy         <= 1'b0;
         event_count  <= '0;
         missed_count <= '0;
      end else begin
         cnt       <= cnt_nxt;
         pulse_out <= pulse_nxt;
         busy      <= busy_nxt;
         if (accept) begin
            d_lat <= delay_cfg;
            w_lat <= (width_cfg == '0) ? CNT_ONE : width_cfg;
         end
         if (stat_clear)  event_count <= '0;
         else if (accept) event_count <= event_count + STAT_ONE;
         if (stat_clear)  missed_count <= '0;
         else if (miss)   missed_count <= missed_count + STAT_ONE;
      end
   end

endmodule

// File: rtl/fsm_trigger_delay_multi.sv
// Multi-channel opto trigger delay block: an array of independent
// trigger_delay_channel instances on flat packed buses.
module fsm_trigger_delay_multi
   import fsm_trigger_pkg::*;
#(
   parameter int CHANNELS    = 4,
   parameter int CNT_WIDTH   = 32,
   parameter int SYNC_STAGES = 2,
   parameter int STAT_WIDTH  = 16
) (
   input  logic                           clock,
   input  logic                           reset_n,
   input  logic [CHANNELS-1:0]            enable,
   input  logic [CHANNELS-1:0]            edge_sel,
   input  logic [CHANNELS-1:0]            sig_in,
   input  logic [CHANNELS*CNT_WIDTH-1:0]  delay_cfg,
   input  logic [CHANNELS*CNT_WIDTH-1:0]  width_cfg,
   input  logic                           stat_clear,
   output logic [CHANNELS-1:0]            pulse_out,
   output logic [CHANNELS-1:0]            busy,
   output logic [CHANNELS*STAT_WIDTH-1:0] event_count,
   output logic [CHANNELS*STAT_WIDTH-1:0] missed_count
);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      trigger_delay_channel #(
         .CNT_WIDTH   (CNT_WIDTH),
         .SYNC_STAGES (SYNC_STAGES),
         .STAT_WIDTH  (STAT_WIDTH)
      ) u_chan (
         .clock        (clock),
         .reset_n      (reset_n),
         .enable       (enable[i]),
         .edge_sel     (edge_sel[i]),
         .sig_in       (sig_in[i]),
         .delay_cfg    (delay_cfg[i*CNT_WIDTH +: CNT_WIDTH]),
         .width_cfg    (width_cfg[i*CNT_WIDTH +: CNT_WIDTH]),
         .stat_clear   (stat_clear),
         .pulse_out    (pulse_out[i]),
         .busy         (busy[i]),
         .event_count  (event_count[i*STAT_WIDTH +: STAT_WIDTH]),
         .missed_count (missed_count[i*STAT_WIDTH +: STAT_WIDTH])
      );
   end

endmodule
